// File: rtl/abs_phase_nfreq.sv
// Multi-frequency heterodyne absolute-phase unwrapper.
// Takes NUM_FREQ wrapped phases of one pixel (highest frequency in slot 0)
// and produces the signed absolute phase of the highest frequency in turns,
// with DATA_WIDTH fractional bits. The whole pipeline shares one enable, so
// a stalled output freezes every stage and backpressures the input.
module abs_phase_nfreq #(
  parameter int DATA_WIDTH  = 16,
  parameter int NUM_FREQ    = 3,
  parameter int RATIO_WIDTH = 8,
  parameter int INT_WIDTH   = 16
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   s_tvalid,
  output logic                                   s_tready,
  input  logic [NUM_FREQ*DATA_WIDTH-1:0]         s_tdata,
  input  logic                                   s_tlast,
  input  logic [(NUM_FREQ-1)*RATIO_WIDTH-1:0]    cfg_ratio,
  output logic                                   m_tvalid,
  input  logic                                   m_tready,
  output logic [INT_WIDTH+DATA_WIDTH-1:0]        m_tdata,
  output logic                                   m_tlast
);

  localparam int DW = DATA_WIDTH;
  localparam int RW = RATIO_WIDTH;
  localparam int NF = NUM_FREQ;
  localparam int NL = NF - 1;          // number of heterodyne / unwrap levels
  localparam int W  = INT_WIDTH + DATA_WIDTH;
  localparam int L  = 4 * NL + 1;      // total register stages
  localparam int NU = 3 * NL;          // unwrap stages

  localparam logic [W-1:0] HALF     = {{INT_WIDTH{1'b0}}, 1'b1, {(DW-1){1'b0}}};
  localparam logic [W-1:0] INT_MASK = {{INT_WIDTH{1'b1}}, {DW{1'b0}}};

  // One unwrap sub-step. Phase 0: scale the coarse estimate by the ratio.
  // Phase 1: subtract E, add one half and floor to a whole turn count.
  // Phase 2: add E back. All arithmetic wraps modulo 2^W.
  function automatic logic [W-1:0] unwrap_step(input int phase,
                                               input logic [W-1:0] acc,
                                               input logic [DW-1:0] ek,
                                               input logic [RW-1:0] ratio);
    logic [W-1:0] ek_ext;
    ek_ext = {{INT_WIDTH{1'b0}}, ek};
    case (phase)
      32'sd0:  unwrap_step = acc * {{(W-RW){1'b0}}, ratio};
      32'sd1:  unwrap_step = (acc - ek_ext + HALF) & INT_MASK;
      32'sd2:  unwrap_step = acc + ek_ext;
      default: unwrap_step = acc;
    endcase
  endfunction

  logic en;
  logic [L-1:0] vld_r;
  logic [L-1:0] lst_r;

  assign en       = ~m_tvalid | m_tready;
  assign s_tready = en & ~rst;
  assign m_tvalid = vld_r[L-1];
  assign m_tlast  = lst_r[L-1];

  // Valid and tlast shift registers; tlast only ever enters alongside a valid beat
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_r <= {L{1'b0}};
      lst_r <= {L{1'b0}};
    end else if (en) begin
      vld_r <= {vld_r[L-2:0], s_tvalid};
      lst_r <= {lst_r[L-2:0], s_tvalid & s_tlast};
    end
  end

  // Heterodyne pipeline. Stage j holds S_j in slots 0..NF-1-j; the freed
  // upper slots keep the earlier E values, E_m living in slot NF-1-m. After
  // the last level every slot is an E value.
  logic [NF*DW-1:0] ph_r [NF];
  logic [NL*RW-1:0] rt_r [NF];

  // Capture the beat together with its ratios; data is don't-care without valid
  always_ff @(posedge clk) begin
    if (en) begin
      ph_r[0] <= s_tdata;
      rt_r[0] <= cfg_ratio;
    end
  end

  for (genvar j = 1; j < NF; j++) begin : g_het
    logic [NF*DW-1:0] het_nxt;

    // Subtract the set's last member from the rest and park E_{j-1} in the freed slot
    always_comb begin
      het_nxt = ph_r[j-1];
      for (int i = 0; i < NF - j; i++) begin
        het_nxt[i*DW +: DW] = ph_r[j-1][i*DW +: DW] - ph_r[j-1][(NF-j)*DW +: DW];
      end
      het_nxt[(NF-j)*DW +: DW] = ph_r[j-1][DW-1:0];
    end

    // Advance one heterodyne level
    always_ff @(posedge clk) begin
      if (en) begin
        ph_r[j] <= het_nxt;
        rt_r[j] <= rt_r[j-1];
      end
    end
  end

  // Unwrap pipeline: three stages per level, coarsest level first. The E
  // vector carried here drops E_{N-1}, so E_k sits in slot (NL-1-k).
  logic [W-1:0]     acc_r [NU];
  logic [NL*DW-1:0] ue_r  [NU-1];
  logic [NL*RW-1:0] ur_r  [NU-1];

  for (genvar u = 0; u < NU; u++) begin : g_unw
    localparam int LV = u / 3;
    localparam int PH = u % 3;
    localparam int K  = NL - 1 - LV;

    if (u == 0) begin : g_first
      // First multiply starts from the coarsest E, zero-extended
      always_ff @(posedge clk) begin
        if (en) begin
          acc_r[0] <= unwrap_step(PH, {{INT_WIDTH{1'b0}}, ph_r[NL][DW-1:0]},
                                  ph_r[NL][DW +: DW], rt_r[NL][K*RW +: RW]);
          ue_r[0]  <= ph_r[NL][NF*DW-1:DW];
          ur_r[0]  <= rt_r[NL];
        end
      end
    end else if (u == NU - 1) begin : g_last
      // Final add doubles as the output register, cleared by reset
      always_ff @(posedge clk) begin
        if (rst) begin
          acc_r[u] <= {W{1'b0}};
        end else if (en) begin
          acc_r[u] <= unwrap_step(PH, acc_r[u-1], ue_r[u-1][LV*DW +: DW],
                                  ur_r[u-1][K*RW +: RW]);
        end
      end
    end else begin : g_mid
      // Intermediate unwrap step, carrying E values and ratios alongside
      always_ff @(posedge clk) begin
        if (en) begin
          acc_r[u] <= unwrap_step(PH, acc_r[u-1], ue_r[u-1][LV*DW +: DW],
                                  ur_r[u-1][K*RW +: RW]);
          ue_r[u]  <= ue_r[u-1];
          ur_r[u]  <= ur_r[u-1];
        end
      end
    end
  end

  assign m_tdata = acc_r[NU-1];

endmodule

// File: tb/tb_abs_phase_nfreq.sv
// Self-checking bench for abs_phase_nfreq: directed table, corner sequences,
// and randomized beats scored against an arithmetic reference model.
module tb_abs_phase_nfreq;

  localparam int L3 = 9;
  localparam int L2 = 5;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_tvalid, s_tready, s_tlast, m_tvalid, m_tready, m_tlast;
  logic [47:0] s_tdata;
  logic [15:0] cfg_ratio;
  logic [31:0] m_tdata;

  logic        s2_tvalid, s2_tready, s2_tlast, m2_tvalid, m2_tready, m2_tlast;
  logic [31:0] s2_tdata;
  logic [7:0]  cfg2_ratio;
  logic [31:0] m2_tdata;

  abs_phase_nfreq #(.DATA_WIDTH(16), .NUM_FREQ(3), .RATIO_WIDTH(8), .INT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata),
    .s_tlast(s_tlast), .cfg_ratio(cfg_ratio), .m_tvalid(m_tvalid), .m_tready(m_tready),
    .m_tdata(m_tdata), .m_tlast(m_tlast));

  abs_phase_nfreq #(.DATA_WIDTH(16), .NUM_FREQ(2), .RATIO_WIDTH(8), .INT_WIDTH(16)) dut2 (
    .clk(clk), .rst(rst), .s_tvalid(s2_tvalid), .s_tready(s2_tready), .s_tdata(s2_tdata),
    .s_tlast(s2_tlast), .cfg_ratio(cfg2_ratio), .m_tvalid(m2_tvalid), .m_tready(m2_tready),
    .m_tdata(m2_tdata), .m_tlast(m2_tlast));

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] p0, p1, p2;
    logic [7:0]  r0, r1;
    logic        last;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic        last;
    int          cyc;
    bit          lat;
  } exp_t;

  vec_t  tbl [6];
  exp_t  sb [$];
  int    n_vec = 0;
  int    n_err = 0;
  int    cyc = 0;
  int    st = 0;
  int    rdy_mode = 0;
  bit    lat_chk = 1'b1;
  bit    rst_seen = 1'b0;
  logic [31:0] exp_cur;
  logic        exp_last;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: heterodyne by repeatedly removing the last set member, then
  // unwrap with real floor arithmetic on scaled integers, wrapped to 32 bits.
  function automatic logic [31:0] model_n(input logic [15:0] ph [$], input logic [7:0] r [$]);
    logic [15:0] s [$];
    logic [15:0] e [4];
    logic [15:0] lastv;
    longint a, t;
    int n;
    n = ph.size();
    s = ph;
    e[0] = s[0];
    for (int j = 1; j < n; j++) begin
      lastv = s.pop_back();
      foreach (s[i]) s[i] = s[i] - lastv;
      e[j] = s[0];
    end
    a = longint'(e[n-1]);
    for (int k = n - 2; k >= 0; k--) begin
      t = a * longint'(r[k]) - longint'(e[k]);
      a = longint'(e[k]) + ((t + 64'sd32768) >>> 16) * 64'sd65536;
      a = longint'($signed(a[31:0]));
    end
    return a[31:0];
  endfunction

  function automatic logic [31:0] model3(input logic [15:0] p0, p1, p2, input logic [7:0] r0, r1);
    logic [15:0] pq [$];
    logic [7:0]  rq [$];
    pq.push_back(p0); pq.push_back(p1); pq.push_back(p2);
    rq.push_back(r0); rq.push_back(r1);
    return model_n(pq, rq);
  endfunction

  task automatic send(input logic [15:0] p0, p1, p2, input logic [7:0] r0, r1,
                      input logic last, input logic [31:0] exp);
    bit acc;
    s_tdata   = {p2, p1, p0};
    cfg_ratio = {r1, r0};
    s_tlast   = last;
    exp_cur   = exp;
    exp_last  = last;
    s_tvalid  = 1'b1;
    acc = 1'b0;
    for (int i = 0; i < 200 && !acc; i++) begin
      @(negedge clk);
      acc = s_tready;
      @(posedge clk);
      #1;
    end
    s_tvalid = 1'b0;
    check("send_accept", 64'(acc), 64'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < 300; i++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
    end
    check("drain_empty", 64'(sb.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor, sampling on the falling edge
  initial begin
    forever begin
      @(negedge clk);
      cyc = cyc + 1;
      if (rst_seen) begin
        check("rst_m_tvalid", 64'(m_tvalid), 64'd0);
        check("rst_m_tlast", 64'(m_tlast), 64'd0);
        check("rst_m_tdata", 64'(m_tdata), 64'd0);
      end
      rst_seen = rst;
      if (rst) begin
        check("rst_s_tready", 64'(s_tready), 64'd0);
        sb.delete();
      end else begin
        if (s_tvalid && s_tready)
          sb.push_back('{data: exp_cur, last: exp_last, cyc: cyc, lat: lat_chk});
        if (m_tvalid) begin
          if (sb.size() == 0) begin
            check("spurious_m_tvalid", 64'(m_tvalid), 64'd0);
          end else begin
            check("m_tdata", 64'(m_tdata), 64'(sb[0].data));
            check("m_tlast", 64'(m_tlast), 64'(sb[0].last));
            if (m_tready) begin
              if (sb[0].lat) check("latency", 64'(cyc - sb[0].cyc), 64'(L3));
              void'(sb.pop_front());
            end
          end
          if (!m_tready) check("stall_s_tready", 64'(s_tready), 64'd0);
        end
      end
    end
  end

  // Downstream ready generator
  initial begin
    m_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        1:       m_tready = ($urandom_range(0, 3) != 0);
        2:       m_tready = !((cyc >= st) && (cyc < st + 5));
        default: m_tready = 1'b1;
      endcase
    end
  end

  initial begin
    logic [15:0] a0, a1, a2;
    logic [7:0]  q0, q1;
    bit          found;

    rst = 1'b1; s_tvalid = 1'b0; s_tlast = 1'b0; s_tdata = 48'd0; cfg_ratio = 16'd0;
    exp_cur = 32'd0; exp_last = 1'b0;
    s2_tvalid = 1'b0; s2_tlast = 1'b0; s2_tdata = 32'd0; cfg2_ratio = 8'd0; m2_tready = 1'b1;

    tbl[0] = '{16'h4000, 16'h7700, 16'hF800, 8'd8, 8'd8, 1'b0, 32'h0032_4000};
    tbl[1] = '{16'h0000, 16'h0000, 16'h0000, 8'd8, 8'd8, 1'b1, 32'h0000_0000};
    tbl[2] = '{16'hFF00, 16'hFF00, 16'hFF00, 8'd8, 8'd8, 1'b0, 32'hFFFF_FF00};
    tbl[3] = '{16'h1234, 16'h0000, 16'h0000, 8'd0, 8'd0, 1'b1, 32'h0000_1234};
    tbl[4] = '{16'hC000, 16'h0000, 16'h0000, 8'd4, 8'd4, 1'b0, 32'h000A_C000};
    tbl[5] = '{16'h8000, 16'h8000, 16'h8000, 8'd2, 8'd2, 1'b1, 32'h0000_8000};

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Directed table, back-to-back, full throughput
    for (int i = 0; i < 6; i++)
      send(tbl[i].p0, tbl[i].p1, tbl[i].p2, tbl[i].r0, tbl[i].r1, tbl[i].last, tbl[i].exp);
    drain();

    // 20 all-zero beats with one tlast
    for (int i = 0; i < 20; i++) send(16'd0, 16'd0, 16'd0, 8'd8, 8'd8, (i == 6), 32'd0);
    drain();

    // Backpressure: 5-cycle stall in the middle of 12 beats
    lat_chk = 1'b0;
    st = cyc + 12;
    rdy_mode = 2;
    for (int i = 0; i < 12; i++) begin
      a0 = 16'(i * 16'h1111) ^ 16'($urandom); a1 = 16'($urandom); a2 = 16'($urandom);
      send(a0, a1, a2, 8'd8, 8'd8, (i == 11), model3(a0, a1, a2, 8'd8, 8'd8));
    end
    drain();
    rdy_mode = 0;

    // Mid-stream reset with 4 beats in flight, then one beat at full latency
    lat_chk = 1'b1;
    for (int i = 0; i < 4; i++) send(tbl[0].p0, tbl[0].p1, tbl[0].p2, 8'd8, 8'd8, 1'b1, tbl[0].exp);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    send(tbl[4].p0, tbl[4].p1, tbl[4].p2, tbl[4].r0, tbl[4].r1, 1'b0, tbl[4].exp);
    drain();

    // Two-frequency build: value and latency
    s2_tdata = {16'h2800, 16'h8000}; cfg2_ratio = 8'd16; s2_tlast = 1'b1; s2_tvalid = 1'b1;
    @(negedge clk);
    check("n2_s_tready", 64'(s2_tready), 64'd1);
    @(posedge clk);
    #1;
    s2_tvalid = 1'b0;
    found = 1'b0;
    for (int i = 1; i <= 20 && !found; i++) begin
      @(negedge clk);
      if (m2_tvalid) begin
        found = 1'b1;
        check("n2_latency", 64'(i), 64'(L2));
        check("n2_m_tdata", 64'(m2_tdata), 64'h0005_8000);
        check("n2_m_tlast", 64'(m2_tlast), 64'd1);
      end
    end
    check("n2_output_seen", 64'(found), 64'd1);
    @(posedge clk);
    #1;

    // Randomized beats, gaps and downstream stalls
    lat_chk = 1'b0;
    rdy_mode = 1;
    for (int i = 0; i < 250; i++) begin
      a0 = 16'($urandom); a1 = 16'($urandom); a2 = 16'($urandom);
      q0 = 8'($urandom_range(0, 255)); q1 = 8'($urandom_range(0, 255));
      if (i % 25 == 0) begin q0 = 8'd0; a2 = 16'hFFFF; end
      send(a0, a1, a2, q0, q1, ($urandom_range(0, 7) == 0), model3(a0, a1, a2, q0, q1));
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
    end
    drain();
    rdy_mode = 0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
